dcache_sram_nway: RTL and testbench

DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

---
 rtl/dcache_sram_nway.sv | 208 ++++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache SRAM with per-set age-based LRU,
// registered lookup port, fill/write port and a dirty-line flush engine
// that walks every (set, way) entry and streams dirty lines out through
// a valid/ready writeback channel.
module dcache_sram_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic                     dirty_i,
  input  logic [$clog2(SETS)-1:0]  addr_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [LINE_W-1:0]        data_i,
  output logic                     rvalid_o,
  output logic                     hit_o,
  output logic [LINE_W-1:0]        data_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     victim_valid_o,
  output logic                     victim_dirty_o,
  input  logic                     flush_i,
  output logic                     flush_busy_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [$clog2(SETS)-1:0]  wb_set_o,
  output logic [TAG_W-1:0]         wb_tag_o,
  output logic [LINE_W-1:0]        wb_data_o,
  output logic                     flush_done_o
);
  localparam int SW = $clog2(SETS);
  localparam int AW = $clog2(WAYS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic              valid    [SETS][WAYS];
  logic              dirty    [SETS][WAYS];
  logic [AW-1:0]     age      [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem [SETS][WAYS];

  logic [1:0]    state;
  logic [SW-1:0] scan_set;
  logic [AW-1:0] scan_way;
  logic [SW-1:0] next_set;
  logic [AW-1:0] next_way;

  logic          busy;
  logic          acc;
  logic          hit;
  logic          scan_last;
  logic          scan_dirty;
  logic          wb_fire;
  logic [AW-1:0] hit_way;
  logic [AW-1:0] vic_way;
  logic [AW-1:0] acc_way;

  // Requests are dropped while the flush engine owns the arrays.
  assign busy       = (state != ST_IDLE);
  assign acc        = req_i && !busy;
  assign scan_last  = (scan_set == SW'(SETS - 1)) && (scan_way == AW'(WAYS - 1));
  assign scan_dirty = valid[scan_set][scan_way] && dirty[scan_set][scan_way];
  assign wb_fire    = (state == ST_WB) && wb_ready_i;
  assign acc_way    = hit ? hit_way : vic_way;

  // Hit detection (lowest matching way wins) and victim choice
  // (lowest invalid way, otherwise the oldest way).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[addr_i][w] && (tag_mem[addr_i][w] == tag_i)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (age[addr_i][w] == AW'(WAYS - 1)) vic_way = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[addr_i][w]) vic_way = AW'(w);
    end
  end

  // Scan pointer successor: way-minor, set-major.
  always_comb begin
    next_set = scan_set;
    next_way = scan_way + 1'b1;
    if (scan_way == AW'(WAYS - 1)) begin
      next_way = '0;
      next_set = scan_set + 1'b1;
    end
  end

  // Valid/dirty/LRU state: accessed way becomes youngest, younger ways age by one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= AW'(w);
        end
      end
    end else begin
      if (acc && (we_i || hit)) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == acc_way) begin
            age[addr_i][w] <= '0;
          end else if (age[addr_i][w] < age[addr_i][acc_way]) begin
            age[addr_i][w] <= age[addr_i][w] + 1'b1;
          end
        end
        if (we_i) begin
          valid[addr_i][acc_way] <= 1'b1;
          dirty[addr_i][acc_way] <= dirty_i;
        end
      end
      if (wb_fire) dirty[scan_set][scan_way] <= 1'b0;
    end
  end

  // Tag and line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (acc && we_i) begin
      tag_mem[addr_i][acc_way]  <= tag_i;
      data_mem[addr_i][acc_way] <= data_i;
    end
  end

  // Lookup result registers: rvalid pulses, the payload holds until the next lookup.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid_o       <= 1'b0;
      hit_o          <= 1'b0;
      data_o         <= '0;
      tag_o          <= '0;
      victim_valid_o <= 1'b0;
      victim_dirty_o <= 1'b0;
    end else begin
      rvalid_o <= acc && !we_i;
      if (acc && !we_i) begin
        hit_o          <= hit;
        data_o         <= data_mem[addr_i][acc_way];
        tag_o          <= tag_mem[addr_i][acc_way];
        victim_valid_o <= !hit && valid[addr_i][vic_way];
        victim_dirty_o <= !hit && valid[addr_i][vic_way] && dirty[addr_i][vic_way];
      end
    end
  end

  // Flush engine: walk every entry, stall in WB until each dirty line is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      scan_set <= '0;
      scan_way <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_i) begin
            state    <= ST_SCAN;
            scan_set <= '0;
            scan_way <= '0;
          end
        end
        ST_SCAN: begin
          if (scan_dirty) begin
            state <= ST_WB;
          end else if (scan_last) begin
            state <= ST_DONE;
          end else begin
            scan_set <= next_set;
            scan_way <= next_way;
          end
        end
        ST_WB: begin
          if (wb_ready_i) begin
            if (scan_last) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_SCAN;
              scan_set <= next_set;
              scan_way <= next_way;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flush_busy_o = busy;
  assign flush_done_o = (state == ST_DONE);
  assign wb_valid_o   = (state == ST_WB);
  assign wb_set_o     = wb_valid_o ? scan_set : '0;
  assign wb_tag_o     = wb_valid_o ? tag_mem[scan_set][scan_way] : '0;
  assign wb_data_o    = wb_valid_o ? data_mem[scan_set][scan_way] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Bench for dcache_sram_nway: a 2-way and a 4-way instance share the request
// port; a recency-list cache model predicts every lookup and flush beat.
module tb_dcache_sram_nway;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic         dty = 1'b0;
  logic [3:0]   addr = '0;
  logic [22:0]  tag = '0;
  logic [255:0] data = '0;
  logic         flush = 1'b0;
  logic         wb_ready = 1'b0;

  logic         rvalid_s [2];
  logic         hit_s    [2];
  logic         vv_s     [2];
  logic         vd_s     [2];
  logic [255:0] data_s   [2];
  logic [22:0]  tag_s    [2];

  logic         busy2, wbv2, done2;
  logic [3:0]   wbset2;
  logic [22:0]  wbtag2;
  logic [255:0] wbdata2;
  logic         busy4, wbv4, done4;
  logic [3:0]   wbset4;
  logic [22:0]  wbtag4;
  logic [255:0] wbdata4;

  int n_vec = 0;
  int n_bad = 0;

  dcache_sram_nway #(.WAYS(2), .SETS(16), .TAG_W(23), .LINE_W(256)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .dirty_i(dty),
    .addr_i(addr), .tag_i(tag), .data_i(data),
    .rvalid_o(rvalid_s[0]), .hit_o(hit_s[0]), .data_o(data_s[0]), .tag_o(tag_s[0]),
    .victim_valid_o(vv_s[0]), .victim_dirty_o(vd_s[0]),
    .flush_i(flush), .flush_busy_o(busy2), .wb_valid_o(wbv2), .wb_ready_i(wb_ready),
    .wb_set_o(wbset2), .wb_tag_o(wbtag2), .wb_data_o(wbdata2), .flush_done_o(done2)
  );

  dcache_sram_nway #(.WAYS(4), .SETS(16), .TAG_W(23), .LINE_W(256)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .dirty_i(dty),
    .addr_i(addr), .tag_i(tag), .data_i(data),
    .rvalid_o(rvalid_s[1]), .hit_o(hit_s[1]), .data_o(data_s[1]), .tag_o(tag_s[1]),
    .victim_valid_o(vv_s[1]), .victim_dirty_o(vd_s[1]),
    .flush_i(1'b0), .flush_busy_o(busy4), .wb_valid_o(wbv4), .wb_ready_i(1'b1),
    .wb_set_o(wbset4), .wb_tag_o(wbtag4), .wb_data_o(wbdata4), .flush_done_o(done4)
  );

  always #5 clk = ~clk;

  // Reference model: per set a recency list (index 0 = most recent).
  bit           m_valid [2][16][4];
  bit           m_dirty [2][16][4];
  logic [22:0]  m_tag   [2][16][4];
  logic [255:0] m_data  [2][16][4];
  int           m_order [2][16][4];

  bit           e_hit [2];
  bit           e_vv  [2];
  bit           e_vd  [2];
  bit           e_known [2];
  logic [22:0]  e_tag [2];
  logic [255:0] e_data [2];

  function automatic int nways(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) begin
          m_valid[d][s][w] = 1'b0;
          m_dirty[d][s][w] = 1'b0;
          m_order[d][s][w] = w;
        end
  endtask

  task automatic touch(input int d, input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < nways(d); i++) if (m_order[d][s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[d][s][i] = m_order[d][s][i-1];
    m_order[d][s][0] = w;
  endtask

  task automatic model_step(input int d, input bit w_e, input bit dy, input int s,
                            input logic [22:0] t, input logic [255:0] dt);
    int nw, hw, vw, w;
    nw = nways(d);
    hw = -1;
    vw = -1;
    for (int i = 0; i < nw; i++) if (m_valid[d][s][i] && m_tag[d][s][i] == t && hw < 0) hw = i;
    for (int i = 0; i < nw; i++) if (!m_valid[d][s][i] && vw < 0) vw = i;
    if (vw < 0) vw = m_order[d][s][nw-1];
    e_hit[d] = (hw >= 0);
    e_vv[d] = 1'b0;
    e_vd[d] = 1'b0;
    e_known[d] = 1'b0;
    if (!w_e) begin
      if (hw >= 0) begin
        e_known[d] = 1'b1;
        e_tag[d] = m_tag[d][s][hw];
        e_data[d] = m_data[d][s][hw];
        touch(d, s, hw);
      end else begin
        e_vv[d] = m_valid[d][s][vw];
        e_vd[d] = m_valid[d][s][vw] && m_dirty[d][s][vw];
        e_known[d] = m_valid[d][s][vw];
        e_tag[d] = m_tag[d][s][vw];
        e_data[d] = m_data[d][s][vw];
      end
    end else begin
      w = (hw >= 0) ? hw : vw;
      m_valid[d][s][w] = 1'b1;
      m_dirty[d][s][w] = dy;
      m_tag[d][s][w] = t;
      m_data[d][s][w] = dt;
      touch(d, s, w);
    end
  endtask

  // Issue one request at a negedge; check both instances at the next negedge.
  task automatic do_req(input bit w_e, input bit dy, input logic [3:0] s,
                        input logic [22:0] t, input logic [255:0] dt);
    req = 1'b1; we = w_e; dty = dy; addr = s; tag = t; data = dt;
    for (int d = 0; d < 2; d++) model_step(d, w_e, dy, s, t, dt);
    @(negedge clk);
    req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!w_e) begin
        chk($sformatf("rvalid%0d", d), rvalid_s[d], 1'b1);
        chk($sformatf("hit%0d s%0d t%0h", d, s, t), hit_s[d], e_hit[d]);
        chk($sformatf("victim_valid%0d", d), vv_s[d], e_vv[d]);
        chk($sformatf("victim_dirty%0d", d), vd_s[d], e_vd[d]);
        if (e_known[d]) begin
          chk($sformatf("tag_o%0d", d), tag_s[d], e_tag[d]);
          chk($sformatf("data_o%0d", d), data_s[d], e_data[d]);
        end
      end else begin
        chk($sformatf("rvalid_wr%0d", d), rvalid_s[d], 1'b0);
      end
    end
  endtask

  // Flush already started on the 2-way instance: expect every dirty line in scan order.
  task automatic flush_body();
    int fs[$];
    int fw[$];
    int c;
    int extra;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 2; w++)
        if (m_valid[0][s][w] && m_dirty[0][s][w]) begin
          fs.push_back(s);
          fw.push_back(w);
        end
    chk("busy_start", busy2, 1'b1);
    foreach (fs[i]) begin
      c = 0;
      while (!wbv2 && c < 300) begin
        @(negedge clk);
        c++;
      end
      chk("wb_valid_wait", wbv2, 1'b1);
      if (!wbv2) return;
      chk("wb_set", wbset2, fs[i]);
      chk("wb_tag", wbtag2, m_tag[0][fs[i]][fw[i]]);
      chk("wb_data", wbdata2, m_data[0][fs[i]][fw[i]]);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("wb_hold_valid", wbv2, 1'b1);
        chk("wb_hold_set", wbset2, fs[i]);
        chk("wb_hold_tag", wbtag2, m_tag[0][fs[i]][fw[i]]);
        chk("wb_hold_data", wbdata2, m_data[0][fs[i]][fw[i]]);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      m_dirty[0][fs[i]][fw[i]] = 1'b0;
    end
    c = 0;
    extra = 0;
    while (!done2 && c < 300) begin
      if (wbv2) extra++;
      @(negedge clk);
      c++;
    end
    chk("flush_done", done2, 1'b1);
    chk("extra_beats", extra, 0);
    @(negedge clk);
    chk("done_pulse_end", done2, 1'b0);
    chk("busy_end", busy2, 1'b0);
  endtask

  task automatic run_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    flush_body();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rvalid%0d", d), rvalid_s[d], 1'b0);
      chk($sformatf("rst_hit%0d", d), hit_s[d], 1'b0);
      chk($sformatf("rst_data%0d", d), data_s[d], '0);
      chk($sformatf("rst_tag%0d", d), tag_s[d], '0);
      chk($sformatf("rst_vv%0d", d), vv_s[d], 1'b0);
      chk($sformatf("rst_vd%0d", d), vd_s[d], 1'b0);
    end
    chk("rst_busy", busy2, 1'b0);
    chk("rst_wbv", wbv2, 1'b0);
    chk("rst_done", done2, 1'b0);
    chk("rst_wbdata", wbdata2, '0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] sets_pick [4];
    int c;
    sets_pick[0] = 4'd0; sets_pick[1] = 4'd1; sets_pick[2] = 4'd2; sets_pick[3] = 4'd15;
    #1;
    apply_reset();

    // Lookup in an empty cache
    do_req(1'b0, 1'b0, 4'd3, 23'h12, '0);
    @(negedge clk);
    chk("rvalid_pulse_end", rvalid_s[0], 1'b0);

    // 2-way LRU eviction in set 5
    do_req(1'b1, 1'b0, 4'd5, 23'hA, rnd_line());
    do_req(1'b1, 1'b1, 4'd5, 23'hB, rnd_line());
    do_req(1'b0, 1'b0, 4'd5, 23'hA, '0);
    chk("r025_A_hit", hit_s[0], 1'b1);
    do_req(1'b1, 1'b0, 4'd5, 23'hC, rnd_line());
    do_req(1'b0, 1'b0, 4'd5, 23'hC, '0);
    chk("r025_C_hit", hit_s[0], 1'b1);
    do_req(1'b0, 1'b0, 4'd5, 23'hB, '0);
    chk("r025_B_miss", hit_s[0], 1'b0);

    // 4-way LRU victim in set 0
    for (int i = 1; i <= 4; i++) do_req(1'b1, (i % 2) == 0, 4'd0, 23'(i), rnd_line());
    do_req(1'b0, 1'b0, 4'd0, 23'd1, '0);
    chk("r026_hit1", hit_s[1], 1'b1);
    do_req(1'b0, 1'b0, 4'd0, 23'd9, '0);
    chk("r026_miss", hit_s[1], 1'b0);
    chk("r026_victim_tag", tag_s[1], 23'd2);
    chk("r026_victim_valid", vv_s[1], 1'b1);
    chk("r026_victim_dirty", vd_s[1], 1'b1);

    // Randomized traffic over a few sets and a small tag space
    for (int i = 0; i < 200; i++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             sets_pick[$urandom_range(0, 3)], 23'($urandom_range(0, 5)), rnd_line());
    run_flush();
    for (int i = 0; i < 40; i++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             sets_pick[$urandom_range(0, 3)], 23'($urandom_range(0, 5)), rnd_line());

    // Two dirty lines, last fill issued together with the flush request
    apply_reset();
    do_req(1'b1, 1'b0, 4'd2, 23'h100, rnd_line());
    do_req(1'b1, 1'b1, 4'd2, 23'h101, rnd_line());
    flush = 1'b1;
    do_req(1'b1, 1'b1, 4'd15, 23'h200, rnd_line());
    flush = 1'b0;
    flush_body();
    run_flush();
    do_req(1'b0, 1'b0, 4'd2, 23'h101, '0);
    chk("r027_hit_2_1", hit_s[0], 1'b1);
    do_req(1'b0, 1'b0, 4'd15, 23'h200, '0);
    chk("r027_hit_15_0", hit_s[0], 1'b1);
    do_req(1'b1, 1'b0, 4'd15, 23'h201, rnd_line());
    do_req(1'b0, 1'b0, 4'd15, 23'h300, '0);
    chk("r027_victim_tag", tag_s[0], 23'h200);
    chk("r027_dirty_cleared", vd_s[0], 1'b0);

    // Reset in the middle of a writeback beat
    do_req(1'b1, 1'b1, 4'd7, 23'h55, rnd_line());
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    c = 0;
    while (!wbv2 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("r028_in_wb", wbv2, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("r028_wbv_drop", wbv2, 1'b0);
    chk("r028_busy_drop", busy2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r028_no_done_rst", done2, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r028_no_done", done2, 1'b0);
    end
    do_req(1'b0, 1'b0, 4'd7, 23'h55, '0);
    chk("r028_miss", hit_s[0], 1'b0);
    do_req(1'b0, 1'b0, 4'd2, 23'h101, '0);
    chk("r028_miss2", hit_s[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
